// File: rtl/jk_cmd_sequencer.sv
// Command FIFO feeding a jk_ff: one registered j/k pair per clock, a shadow
// model of the flop's q, and a sticky flag raised if the flop's q disagrees with it.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd,
  input  logic          pause,
  output logic          j,
  output logic          k,
  input  logic          q_in,
  output logic          exp_q,
  output logic [AW:0]   count,
  output logic [CW-1:0] issued,
  output logic          mismatch,
  output logic          busy
);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state_reg, state_next;
  logic          chk_en_reg, chk_en_next;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic [CW-1:0] issued_reg;
  logic          j_reg, k_reg, j_next, k_next;
  logic          exp_q_reg, exp_q_next;
  logic          mismatch_reg;
  logic          push, pop;
  logic [1:0]    head;

  // Both handshake decisions use only the registered count, so a word written
  // at an edge can never be popped at that same edge.
  assign cmd_ready = (count_reg < (AW+1)'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (count_reg != '0) && !pause;
  assign head      = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= INIT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    chk_en_next = chk_en_reg;
    case (state_reg)
      INIT: begin
        state_next  = RUN;
        chk_en_next = 1'b1;
      end
      RUN: state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Command encoding is HOLD=00, RESET=01, SET=10, TOGGLE=11, which is j/k directly.
  always_comb begin
    j_next = 1'b0;
    k_next = 1'b0;
    if (pop) begin
      j_next = head[1];
      k_next = head[0];
    end
  end

  always_comb begin
    exp_q_next = exp_q_reg;
    case ({j_reg, k_reg})
      2'b01:   exp_q_next = 1'b0;
      2'b10:   exp_q_next = 1'b1;
      2'b11:   exp_q_next = ~exp_q_reg;
      default: exp_q_next = exp_q_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      issued_reg   <= '0;
      j_reg        <= 1'b0;
      k_reg        <= 1'b1;  // force-clear the reset-less flop
      exp_q_reg    <= 1'b0;
      chk_en_reg   <= 1'b0;
      mismatch_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        issued_reg <= issued_reg + 1'b1;
      end
      count_reg  <= count_next;
      j_reg      <= j_next;
      k_reg      <= k_next;
      exp_q_reg  <= exp_q_next;
      chk_en_reg <= chk_en_next;
      if (chk_en_reg && (q_in != exp_q_reg)) mismatch_reg <= 1'b1;
    end
  end

  assign j        = j_reg;
  assign k        = k_reg;
  assign exp_q    = exp_q_reg;
  assign count    = count_reg;
  assign issued   = issued_reg;
  assign mismatch = mismatch_reg;
  assign busy     = (count_reg != '0);

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed/randomized bench for jk_cmd_sequencer with a queue-based reference
// model and a behavioural jk_ff whose output can be inverted to fake a fault.
module tb_jk_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst, cmd_valid, pause, q_in;
  logic [1:0]    cmd;
  logic          cmd_ready, j, k, exp_q, mismatch, busy;
  logic [AW:0]   count;
  logic [CW-1:0] issued;

  logic q_ff;
  logic inv;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [1:0]    mq [$];
  logic [CW-1:0] m_issued;
  logic          m_j, m_k, m_exp, m_chk, m_mm;
  int            m_pushed;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .pause(pause), .j(j), .k(k), .q_in(q_in), .exp_q(exp_q),
    .count(count), .issued(issued), .mismatch(mismatch), .busy(busy)
  );

  always #5 clk = ~clk;

  // behavioural jk_ff with no reset
  always @(posedge clk) begin
    case ({j, k})
      2'b01:   q_ff <= 1'b0;
      2'b10:   q_ff <= 1'b1;
      2'b11:   q_ff <= ~q_ff;
      default: q_ff <= q_ff;
    endcase
  end
  assign q_in = q_ff ^ inv;

  function automatic logic jk_next(input logic q, input logic jj, input logic kk);
    if (jj && kk) return ~q;
    if (jj)       return 1'b1;
    if (kk)       return 1'b0;
    return q;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: apply inputs, advance the model, compare every output.
  task automatic step(input logic v, input logic [1:0] c, input logic p, input logic r);
    logic       qin_pre;
    logic [1:0] hc;
    logic       ready_pre, pop_pre;
    cmd_valid = v; cmd = c; pause = p; rst = r;
    #1;
    qin_pre   = q_in;
    ready_pre = (mq.size() < DEPTH);
    pop_pre   = (mq.size() > 0) && !p;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      m_issued = '0; m_j = 1'b0; m_k = 1'b1; m_exp = 1'b0; m_chk = 1'b0; m_mm = 1'b0;
    end else begin
      if (m_chk && (qin_pre !== m_exp)) m_mm = 1'b1;
      m_exp = jk_next(m_exp, m_j, m_k);
      m_chk = 1'b1;
      if (pop_pre) begin
        hc = mq.pop_front();
        m_issued++;
        case (hc)
          2'd0: begin m_j = 1'b0; m_k = 1'b0; end  // HOLD
          2'd1: begin m_j = 1'b0; m_k = 1'b1; end  // RESET
          2'd2: begin m_j = 1'b1; m_k = 1'b0; end  // SET
          default: begin m_j = 1'b1; m_k = 1'b1; end  // TOGGLE
        endcase
      end else begin
        m_j = 1'b0; m_k = 1'b0;
      end
      if (v && ready_pre) begin
        mq.push_back(c);
        m_pushed++;
      end
    end
    chk("count", 32'(count), 32'(mq.size()));
    chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
    chk("busy", 32'(busy), 32'(mq.size() != 0));
    chk("jk", 32'({j, k}), 32'({m_j, m_k}));
    chk("issued", 32'(issued), 32'(m_issued));
    chk("exp_q", 32'(exp_q), 32'(m_exp));
    chk("mismatch", 32'(mismatch), 32'(m_mm));
  endtask

  initial begin
    logic [1:0] seq [4];
    int guard;
    seq[0] = 2'd2; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3;
    inv = 1'b0; m_pushed = 0;
    m_issued = '0; m_j = 1'b0; m_k = 1'b1; m_exp = 1'b0; m_chk = 1'b0; m_mm = 1'b0;

    // reset
    repeat (3) step(1'b0, 2'd0, 1'b0, 1'b1);
    chk("rst_k", 32'(k), 32'd1);

    // 1: SET, RESET, SET, TOGGLE back-to-back
    for (int i = 0; i < 4; i++) step(1'b1, seq[i], 1'b0, 1'b0);
    repeat (5) step(1'b0, 2'd0, 1'b0, 1'b0);
    chk("t1_q", 32'(q_ff), 32'd0);
    chk("t1_issued", 32'(issued), 32'd4);

    // 2: fill while paused, 5th held off, then drain
    for (int i = 0; i < 6; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
    chk("t2_full", 32'(count), 32'd4);
    repeat (6) step(1'b0, 2'd0, 1'b0, 1'b0);

    // 3: steady stream, push and pop at the same edge
    for (int i = 0; i < 22; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    repeat (6) step(1'b0, 2'd0, 1'b0, 1'b0);
    chk("t3_q", 32'(q_ff), 32'(m_exp));

    // 4: flop output diverges for a while, mismatch must stay sticky
    for (int i = 0; i < 4; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    inv = 1'b1;
    repeat (2) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    inv = 1'b0;
    repeat (6) step(1'b0, 2'd0, 1'b0, 1'b0);
    chk("t4_sticky", 32'(mismatch), 32'd1);

    // 5: reset with three commands queued
    for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 1'b1, 1'b0);
    chk("t5_pre", 32'(count), 32'd3);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_mm", 32'(mismatch), 32'd0);
    repeat (4) step(1'b0, 2'd0, 1'b0, 1'b0);
    chk("t5_q", 32'(q_ff), 32'd0);

    // 6: 256 TOGGLEs, issued wraps
    m_pushed = 0;
    guard = 0;
    while (m_pushed < 256 && guard < 3000) begin
      step(1'b1, 2'd3, ($urandom_range(0, 3) == 0), 1'b0);
      guard++;
    end
    chk("t6_pushed", 32'(m_pushed), 32'd256);
    repeat (8) step(1'b0, 2'd0, 1'b0, 1'b0);
    chk("t6_wrap", 32'(issued), 32'd0);
    chk("t6_q", 32'(q_ff), 32'd0);
    chk("t6_exp", 32'(exp_q), 32'd0);
    chk("t6_mm", 32'(mismatch), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
Upstream command stage for jk_ff. It accepts 2-bit flip-flop commands (HOLD/RESET/SET/TOGGLE) over a valid/ready handshake and buffers them in a small FIFO. It issues one registered j/k pair per clock to the flop. A shadow model of the flop tracks the expected q, compares it against the flop's q, and raises a sticky mismatch flag on any disagreement. It also forces the flop into a known state after reset, because jk_ff has no reset of its own.

Parameters:
DEPTH, 4, FIFO depth in commands (power of 2, ≥2)
AW, 2, log2(DEPTH); pointer width
CW, 8, width of issued-command counter

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
cmd_valid  input  1  upstream command valid
cmd_ready  output  1  FIFO can accept (registered-count based)
cmd  input  2  00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
pause  input  1  1 = no pop; drive j=0,k=0
j  output  1  to jk_ff j (registered)
k  output  1  to jk_ff k (registered)
q_in  input  1  jk_ff q feedback
exp_q  output  1  shadow-model expected q
count  output  AW+1  FIFO occupancy, 0..DEPTH
issued  output  CW  popped-command counter, wraps
mismatch  output  1  sticky: q_in != exp_q seen while checking
busy  output  1  count != 0

Behaviour:
- Reset (rst=1 at an edge) sets:
  - FIFO empty, count=0, issued=0, mismatch=0.
  - j=0, k=1 (force-clear), exp_q=0, chk_en=0.
  - state=INIT.
- Reset dominates all other inputs. Reset mid-operation flushes the FIFO; queued commands are lost.
- FSM states:
  - INIT: lasts exactly one cycle after rst deasserts. The flop samples j=0/k=1 at the exiting edge, so q=0. At that edge: state→RUN, chk_en←1.
  - RUN: remains until rst.
- Push: cmd_valid && cmd_ready at an edge writes cmd at the tail. cmd_ready = (count < DEPTH), valid in any state including INIT. cmd_ready does not depend on a same-cycle pop, so at full a push is rejected even while popping.
- Pop: happens at every non-reset edge where count>0 && !pause, including the INIT-exit edge.
  - The head command is decoded into j/k: HOLD→00, RESET→01, SET→10, TOGGLE→11.
  - issued increments by 1, wrapping modulo 2^CW.
- No pop (FIFO empty or pause=1): j←0, k←0 (hold).
- A pushed entry is never popped at the same edge it is written. An empty FIFO therefore adds one cycle.
- Simultaneous push and pop when 0<count<DEPTH: count is unchanged; pointers wrap modulo DEPTH.
- Latency:
  - Command accepted at edge E.
  - Earliest j/k at E+1.
  - Flop q updated at E+2.
- Shadow model: at every non-reset edge, exp_q ← JK(exp_q, j, k), using the current registered j,k outputs (00 hold, 01→0, 10→1, 11→~exp_q). This is the same function jk_ff applies.
- Check: at each non-reset edge with chk_en=1, if q_in != exp_q then mismatch←1. mismatch stays set until rst. The first comparison occurs at the second edge after reset release.
- busy and count reflect the registered occupancy.

Test Plan:
1. Reset, then push SET, RESET, SET, TOGGLE back-to-back with pause=0.
   - j/k sequence after INIT: 10, 01, 10, 11, then 00.
   - jk_ff q: 1, 0, 1, 0.
   - exp_q tracks q; mismatch=0; issued=4.
2. pause=1, push 5 commands with DEPTH=4.
   - First 4 accepted.
   - cmd_ready=0 at count=4; 5th held off.
   - j=k=0 throughout.
   - Release pause: one pop per cycle; cmd_ready re-asserts the cycle after count drops to 3.
3. Steady stream with push and pop at the same edge.
   - count stays constant and pointers wrap past DEPTH.
   - Commands issue in FIFO order with no loss or duplication, verified over 20 commands.
4. Replace jk_ff with a stub that inverts q after the 3rd command.
   - mismatch rises at the edge after the divergence and stays 1 while later q agrees.
   - Only rst clears it.
5. Assert rst while count=3 mid-stream.
   - Next edge: count=0, issued=0, j=0/k=1, exp_q=0, mismatch=0.
   - After release, flop q=0 and no stale commands issue.
6. Issue 256 TOGGLE commands with CW=8.
   - issued wraps to 0.
   - q and exp_q end at 0 (even count); mismatch=0.
